multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Moore FSM that sequences a multi-cycle MIPS datapath (IF, ID, EX, MEM, WB) for the core instruction subset.
- Issues per-state control strobes for the PC, IR, register file, ALU and a shared instruction/data memory.
- Waits on a memory ready handshake and counts retired instructions.
- Sits between the IR opcode field and the datapath muxes/enables.

Parameters:
- CNT_W, 32, width of retired-instruction counter o_retired

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  synchronous active-high reset
- i_opcode  in  6  IR[31:26]; stable except when o_irWrite fires
- i_memReady  in  1  memory completes current read/write this cycle
- o_pcWrite  out  1  unconditional PC load
- o_pcWriteBeq  out  1  PC load if ALU zero
- o_pcWriteBne  out  1  PC load if ALU not zero
- o_pcSrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
- o_iorD  out  1  memory address: 0 PC, 1 ALUOut
- o_memRead  out  1  memory read request
- o_memWrite  out  1  memory write request
- o_irWrite  out  1  IR load
- o_regDst  out  1  1 rd, 0 rt
- o_regWrite  out  1  register file write
- o_memtoReg  out  1  1 MDR, 0 ALUOut
- o_extOp  out  1  1 sign-extend, 0 zero-extend immediate
- o_aluSrcA  out  1  0 PC, 1 reg A
- o_aluSrcB  out  2  00 reg B, 01 const 4, 10 ext imm, 11 ext imm<<2
- o_aluOp  out  2  00 add, 01 sub, 10 funct-decoded, 11 opcode-decoded
- o_instrDone  out  1  one-cycle pulse in last state of each instruction
- o_illegal  out  1  high while in TRAP
- o_retired  out  CNT_W  instructions completed, wraps modulo 2^CNT_W

Behaviour:
- Opcodes: R 0x00, addi 0x08, slti 0x0A, andi 0x0C, ori 0x0D, xori 0x0E, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, j 0x02.
- Outputs are a pure function of the registered state. Every output not listed for a state is 0.
- Reset: i_rst sampled high takes state to IDLE and sets o_retired to 0, overriding any state or wait. IDLE drives all outputs 0 and goes to FETCH next cycle.
- FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSrc=00.
  - irWrite and pcWrite assert only when i_memReady=1; otherwise stay in FETCH.
  - Next state is DECODE on i_memReady.
- DECODE: aluSrcA=0, aluSrcB=11, aluOp=00, extOp=1 (branch target into ALUOut).
  - Dispatch on i_opcode: R→EXEC_R; addi/slti/andi/ori/xori→EXEC_I; lw/sw→MEM_ADDR; beq/bne→BRANCH; j→JUMP; other→TRAP.
- EXEC_R: aluSrcA=1, aluSrcB=00, aluOp=10 → WB_R.
- WB_R: regDst=1, regWrite=1, memtoReg=0, instrDone=1 → FETCH.
- EXEC_I: aluSrcA=1, aluSrcB=10, aluOp=11; extOp=1 for addi/slti, 0 for andi/ori/xori → WB_I.
- WB_I: regDst=0, regWrite=1, memtoReg=0, instrDone=1 → FETCH.
- MEM_ADDR: aluSrcA=1, aluSrcB=10, aluOp=00, extOp=1 → MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: memRead=1, iorD=1; hold until i_memReady → MEM_WB.
- MEM_WB: regDst=0, regWrite=1, memtoReg=1, instrDone=1 → FETCH.
- MEM_WRITE: memWrite=1, iorD=1; instrDone=i_memReady; hold until i_memReady → FETCH.
- BRANCH: aluSrcA=1, aluSrcB=00, aluOp=01, pcSrc=01; pcWriteBeq (beq) or pcWriteBne (bne); instrDone=1 → FETCH.
- JUMP: pcWrite=1, pcSrc=10, instrDone=1 → FETCH.
- TRAP: o_illegal=1, all other outputs 0; absorbing until reset; o_retired frozen.
- o_retired increments by 1 on every cycle with o_instrDone=1.
- Zero-wait latency: R / I-ALU / sw = 4 cycles; lw = 5; beq / bne / j = 3. Each memory wait cycle adds 1.
- Reset asserted during a memory wait aborts the access; memRead/memWrite drop on the following cycle (IDLE).

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants;
  - state enum (IDLE, FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, BRANCH, JUMP, TRAP);
  - encodings for aluOp, aluSrcB and pcSrc.
- One combinational sub-module, mc_ctrl_decode, maps (state, opcode, i_memReady) to the control word.
- Top keeps the state register, next-state logic and retired counter.

Test Plan:
- Reset, then i_memReady tied 1, opcode 0x00: states IDLE, FETCH, DECODE, EXEC_R, WB_R. regWrite=1 and regDst=1 in cycle 5 only; o_retired=1 after.
- lw (0x23) with i_memReady low 2 cycles in MEM_READ: memRead+iorD held 3 cycles, MEM_WB asserts memtoReg=1 and regWrite=1; total 7 cycles.
- Back-to-back beq (0x04), bne (0x05), j (0x02), ready=1: each takes 3 cycles. Strobes pcWriteBeq, pcWriteBne, then pcWrite with pcSrc=10 respectively. o_retired=3.
- andi (0x0C) vs addi (0x08): EXEC_I extOp=0 vs 1, aluSrcB=10, aluOp=11.
- Opcode 0x3F: DECODE→TRAP, o_illegal=1 held 10+ cycles, o_retired unchanged; i_rst=1 → IDLE, o_illegal=0.
- i_rst=1 mid MEM_WRITE with i_memReady=0: next cycle memWrite=0, o_retired=0, then FETCH. Separately, preload o_retired to all-ones via CNT_W=4 and 16 instructions: wraps to 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: opcodes, FSM states,
// datapath mux encodings and the control word carried from decoder to top.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I,
        MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, BRANCH, JUMP, TRAP
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10, ALU_OPCODE = 2'b11
    } aluOp_t;

    typedef enum logic [1:0] {
        SRCB_REG = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH2 = 2'b11
    } aluSrcB_t;

    typedef enum logic [1:0] {
        PCSRC_ALU = 2'b00, PCSRC_ALUOUT = 2'b01, PCSRC_JUMP = 2'b10
    } pcSrc_t;

    typedef struct packed {
        logic     pcWrite;
        logic     pcWriteBeq;
        logic     pcWriteBne;
        pcSrc_t   pcSrc;
        logic     iorD;
        logic     memRead;
        logic     memWrite;
        logic     irWrite;
        logic     regDst;
        logic     regWrite;
        logic     memtoReg;
        logic     extOp;
        logic     aluSrcA;
        aluSrcB_t aluSrcB;
        aluOp_t   aluOp;
        logic     instrDone;
        logic     illegal;
    } ctrl_t;

    // Where DECODE goes for a given opcode; unknown opcodes land in TRAP.
    function automatic state_t dispatch(input logic [5:0] opcode);
        case (opcode)
            OP_RTYPE:                                   return EXEC_R;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: return EXEC_I;
            OP_LW, OP_SW:                               return MEM_ADDR;
            OP_BEQ, OP_BNE:                             return BRANCH;
            OP_J:                                       return JUMP;
            default:                                    return TRAP;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control-word decoder: state plus opcode and memory ready
// produce every datapath strobe for the current cycle.
module mc_ctrl_decode
    import mips_pkg::*;
(
    input  state_t      state,
    input  logic [5:0]  opcode,
    input  logic        memReady,
    output ctrl_t       ctrl
);

    always_comb begin
        // NOTE: default the whole word first so no path through the case infers a latch.
        ctrl = '0;
        unique case (state)
            FETCH: begin
                ctrl.memRead = 1'b1;
                ctrl.aluSrcB = SRCB_FOUR;
                ctrl.irWrite = memReady;
                ctrl.pcWrite = memReady;
            end
            DECODE: begin
                ctrl.aluSrcB = SRCB_IMM_SH2;
                ctrl.extOp   = 1'b1;
            end
            EXEC_R: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluOp   = ALU_FUNCT;
            end
            WB_R: begin
                ctrl.regDst    = 1'b1;
                ctrl.regWrite  = 1'b1;
                ctrl.instrDone = 1'b1;
            end
            EXEC_I: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_IMM;
                ctrl.aluOp   = ALU_OPCODE;
                // Logical immediates are zero-extended, arithmetic ones sign-extended.
                ctrl.extOp   = (opcode == OP_ADDI) || (opcode == OP_SLTI);
            end
            WB_I: begin
                ctrl.regWrite  = 1'b1;
                ctrl.instrDone = 1'b1;
            end
            MEM_ADDR: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_IMM;
                ctrl.extOp   = 1'b1;
            end
            MEM_READ: begin
                ctrl.memRead = 1'b1;
                ctrl.iorD    = 1'b1;
            end
            MEM_WB: begin
                ctrl.regWrite  = 1'b1;
                ctrl.memtoReg  = 1'b1;
                ctrl.instrDone = 1'b1;
            end
            MEM_WRITE: begin
                ctrl.memWrite  = 1'b1;
                ctrl.iorD      = 1'b1;
                ctrl.instrDone = memReady;
            end
            BRANCH: begin
                ctrl.aluSrcA    = 1'b1;
                ctrl.aluOp      = ALU_SUB;
                ctrl.pcSrc      = PCSRC_ALUOUT;
                ctrl.pcWriteBeq = (opcode == OP_BEQ);
                ctrl.pcWriteBne = (opcode == OP_BNE);
                ctrl.instrDone  = 1'b1;
            end
            JUMP: begin
                ctrl.pcWrite   = 1'b1;
                ctrl.pcSrc     = PCSRC_JUMP;
                ctrl.instrDone = 1'b1;
            end
            TRAP: ctrl.illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: state register, next-state logic and the
// retired-instruction counter; strobes come from mc_ctrl_decode.
module multicycle_control
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [5:0]       i_opcode,
    input  logic             i_memReady,
    output logic             o_pcWrite,
    output logic             o_pcWriteBeq,
    output logic             o_pcWriteBne,
    output logic [1:0]       o_pcSrc,
    output logic             o_iorD,
    output logic             o_memRead,
    output logic             o_memWrite,
    output logic             o_irWrite,
    output logic             o_regDst,
    output logic             o_regWrite,
    output logic             o_memtoReg,
    output logic             o_extOp,
    output logic             o_aluSrcA,
    output logic [1:0]       o_aluSrcB,
    output logic [1:0]       o_aluOp,
    output logic             o_instrDone,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_retired
);

    state_t           state, nextState;
    ctrl_t            ctrl;
    logic [CNT_W-1:0] retired;

    always_ff @(posedge i_clk) begin
        // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
        if (i_rst) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:      nextState = FETCH;
            FETCH:     if (i_memReady) nextState = DECODE;
            DECODE:    nextState = dispatch(i_opcode);
            EXEC_R:    nextState = WB_R;
            EXEC_I:    nextState = WB_I;
            MEM_ADDR:  nextState = (i_opcode == OP_LW) ? MEM_READ : MEM_WRITE;
            MEM_READ:  if (i_memReady) nextState = MEM_WB;
            MEM_WRITE: if (i_memReady) nextState = FETCH;
            WB_R, WB_I, MEM_WB, BRANCH, JUMP: nextState = FETCH;
            TRAP:      nextState = TRAP;
            default:   nextState = IDLE;
        endcase
    end

    mc_ctrl_decode u_decode (
        .state    (state),
        .opcode   (i_opcode),
        .memReady (i_memReady),
        .ctrl     (ctrl)
    );

    // Counter wraps naturally; TRAP never raises instrDone so it stays frozen there.
    always_ff @(posedge i_clk) begin
        if (i_rst)               retired <= '0;
        else if (ctrl.instrDone) retired <= retired + CNT_W'(1);
    end

    assign o_pcWrite    = ctrl.pcWrite;
    assign o_pcWriteBeq = ctrl.pcWriteBeq;
    assign o_pcWriteBne = ctrl.pcWriteBne;
    assign o_pcSrc      = ctrl.pcSrc;
    assign o_iorD       = ctrl.iorD;
    assign o_memRead    = ctrl.memRead;
    assign o_memWrite   = ctrl.memWrite;
    assign o_irWrite    = ctrl.irWrite;
    assign o_regDst     = ctrl.regDst;
    assign o_regWrite   = ctrl.regWrite;
    assign o_memtoReg   = ctrl.memtoReg;
    assign o_extOp      = ctrl.extOp;
    assign o_aluSrcA    = ctrl.aluSrcA;
    assign o_aluSrcB    = ctrl.aluSrcB;
    assign o_aluOp      = ctrl.aluOp;
    assign o_instrDone  = ctrl.instrDone;
    assign o_illegal    = ctrl.illegal;
    assign o_retired    = retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each scripted cycle pushes the
// expected strobes and counter value, which are popped and compared mid-cycle.
module tb_multicycle_control;

    localparam int B_PCW = 19, B_BEQ = 18, B_BNE = 17, B_PCSRC = 15, B_IORD = 14;
    localparam int B_MRD = 13, B_MWR = 12, B_IRW = 11, B_RDST = 10, B_RWR = 9;
    localparam int B_M2R = 8, B_EXT = 7, B_SRCA = 6, B_SRCB = 4, B_ALUOP = 2;
    localparam int B_DONE = 1, B_ILL = 0;

    typedef struct {
        string       tag;
        logic [19:0] ctrl;
        logic [31:0] retired;
    } sbEntry_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic        memReady;

    logic        pcWrite, pcWriteBeq, pcWriteBne, iorD, memRead, memWrite, irWrite;
    logic        regDst, regWrite, memtoReg, extOp, aluSrcA, instrDone, illegal;
    logic [1:0]  pcSrc, aluSrcB, aluOp;
    logic [31:0] retired;

    logic        pcWrite4, pcWriteBeq4, pcWriteBne4, iorD4, memRead4, memWrite4, irWrite4;
    logic        regDst4, regWrite4, memtoReg4, extOp4, aluSrcA4, instrDone4, illegal4;
    logic [1:0]  pcSrc4, aluSrcB4, aluOp4;
    logic [3:0]  retired4;

    logic [19:0] obs, obs4;
    sbEntry_t    sbQ[$];
    logic [31:0] expRet;
    int          testCount = 0;
    int          failCount = 0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .i_clk(clk), .i_rst(rst), .i_opcode(opcode), .i_memReady(memReady),
        .o_pcWrite(pcWrite), .o_pcWriteBeq(pcWriteBeq), .o_pcWriteBne(pcWriteBne),
        .o_pcSrc(pcSrc), .o_iorD(iorD), .o_memRead(memRead), .o_memWrite(memWrite),
        .o_irWrite(irWrite), .o_regDst(regDst), .o_regWrite(regWrite),
        .o_memtoReg(memtoReg), .o_extOp(extOp), .o_aluSrcA(aluSrcA),
        .o_aluSrcB(aluSrcB), .o_aluOp(aluOp), .o_instrDone(instrDone),
        .o_illegal(illegal), .o_retired(retired)
    );

    multicycle_control #(.CNT_W(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_opcode(opcode), .i_memReady(memReady),
        .o_pcWrite(pcWrite4), .o_pcWriteBeq(pcWriteBeq4), .o_pcWriteBne(pcWriteBne4),
        .o_pcSrc(pcSrc4), .o_iorD(iorD4), .o_memRead(memRead4), .o_memWrite(memWrite4),
        .o_irWrite(irWrite4), .o_regDst(regDst4), .o_regWrite(regWrite4),
        .o_memtoReg(memtoReg4), .o_extOp(extOp4), .o_aluSrcA(aluSrcA4),
        .o_aluSrcB(aluSrcB4), .o_aluOp(aluOp4), .o_instrDone(instrDone4),
        .o_illegal(illegal4), .o_retired(retired4)
    );

    assign obs  = {pcWrite, pcWriteBeq, pcWriteBne, pcSrc, iorD, memRead, memWrite,
                   irWrite, regDst, regWrite, memtoReg, extOp, aluSrcA, aluSrcB,
                   aluOp, instrDone, illegal};
    assign obs4 = {pcWrite4, pcWriteBeq4, pcWriteBne4, pcSrc4, iorD4, memRead4, memWrite4,
                   irWrite4, regDst4, regWrite4, memtoReg4, extOp4, aluSrcA4, aluSrcB4,
                   aluOp4, instrDone4, illegal4};

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Expected control words, one per state as the controller's truth table lists them.
    function automatic logic [19:0] eFetch(input logic r);
        logic [19:0] w = '0;
        w[B_MRD] = 1'b1; w[B_SRCB +: 2] = 2'b01;
        w[B_IRW] = r;    w[B_PCW] = r;
        return w;
    endfunction
    function automatic logic [19:0] eDecode();
        logic [19:0] w = '0;
        w[B_SRCB +: 2] = 2'b11; w[B_EXT] = 1'b1;
        return w;
    endfunction
    function automatic logic [19:0] eExecR();
        logic [19:0] w = '0;
        w[B_SRCA] = 1'b1; w[B_ALUOP +: 2] = 2'b10;
        return w;
    endfunction
    function automatic logic [19:0] eWbR();
        logic [19:0] w = '0;
        w[B_RDST] = 1'b1; w[B_RWR] = 1'b1; w[B_DONE] = 1'b1;
        return w;
    endfunction
    function automatic logic [19:0] eExecI(input logic ext);
        logic [19:0] w = '0;
        w[B_SRCA] = 1'b1; w[B_SRCB +: 2] = 2'b10; w[B_ALUOP +: 2] = 2'b11; w[B_EXT] = ext;
        return w;
    endfunction
    function automatic logic [19:0] eWbI();
        logic [19:0] w = '0;
        w[B_RWR] = 1'b1; w[B_DONE] = 1'b1;
        return w;
    endfunction
    function automatic logic [19:0] eMemAddr();
        logic [19:0] w = '0;
        w[B_SRCA] = 1'b1; w[B_SRCB +: 2] = 2'b10; w[B_EXT] = 1'b1;
        return w;
    endfunction
    function automatic logic [19:0] eMemRead();
        logic [19:0] w = '0;
        w[B_MRD] = 1'b1; w[B_IORD] = 1'b1;
        return w;
    endfunction
    function automatic logic [19:0] eMemWb();
        logic [19:0] w = '0;
        w[B_RWR] = 1'b1; w[B_M2R] = 1'b1; w[B_DONE] = 1'b1;
        return w;
    endfunction
    function automatic logic [19:0] eMemWrite(input logic r);
        logic [19:0] w = '0;
        w[B_MWR] = 1'b1; w[B_IORD] = 1'b1; w[B_DONE] = r;
        return w;
    endfunction
    function automatic logic [19:0] eBranch(input logic isBeq);
        logic [19:0] w = '0;
        w[B_SRCA] = 1'b1; w[B_ALUOP +: 2] = 2'b01; w[B_PCSRC +: 2] = 2'b01;
        w[B_BEQ] = isBeq; w[B_BNE] = ~isBeq; w[B_DONE] = 1'b1;
        return w;
    endfunction
    function automatic logic [19:0] eJump();
        logic [19:0] w = '0;
        w[B_PCW] = 1'b1; w[B_PCSRC +: 2] = 2'b10; w[B_DONE] = 1'b1;
        return w;
    endfunction
    function automatic logic [19:0] eTrap();
        logic [19:0] w = '0;
        w[B_ILL] = 1'b1;
        return w;
    endfunction

    // Called just after a falling edge: drive, record expectation, sample, advance.
    task automatic cycle(input string tag, input logic r, input logic [5:0] op,
                         input logic rdy, input logic [19:0] expCtrl);
        sbEntry_t e;
        rst = r; opcode = op; memReady = rdy;
        e.tag = tag; e.ctrl = expCtrl; e.retired = expRet;
        sbQ.push_back(e);
        if (r)                    expRet = '0;
        else if (expCtrl[B_DONE]) expRet = expRet + 32'd1;
        #1;
        e = sbQ.pop_front();
        check({e.tag, ".ctrl"}, {12'h0, obs}, {12'h0, e.ctrl});
        check({e.tag, ".ctrl4"}, {12'h0, obs4}, {12'h0, e.ctrl});
        check({e.tag, ".ret"}, retired, e.retired);
        check({e.tag, ".ret4"}, {28'h0, retired4}, {28'h0, e.retired[3:0]});
        @(negedge clk);
    endtask

    task automatic runJump(input string tag);
        cycle({tag, ".fetch"},  1'b0, 6'h02, 1'b1, eFetch(1'b1));
        cycle({tag, ".decode"}, 1'b0, 6'h02, 1'b1, eDecode());
        cycle({tag, ".jump"},   1'b0, 6'h02, 1'b1, eJump());
    endtask

    logic [5:0] iOps [5] = '{6'h0C, 6'h08, 6'h0A, 6'h0D, 6'h0E};
    logic       iExt [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        rst = 1'b1; opcode = 6'h00; memReady = 1'b1; expRet = '0;
        @(negedge clk);

        // R-type with ready tied high
        cycle("r.idle",   1'b0, 6'h00, 1'b1, '0);
        cycle("r.fetch",  1'b0, 6'h00, 1'b1, eFetch(1'b1));
        cycle("r.decode", 1'b0, 6'h00, 1'b1, eDecode());
        cycle("r.exec",   1'b0, 6'h00, 1'b1, eExecR());
        cycle("r.wb",     1'b0, 6'h00, 1'b1, eWbR());

        // lw with two wait cycles in MEM_READ
        cycle("lw.fetch",  1'b0, 6'h23, 1'b1, eFetch(1'b1));
        cycle("lw.decode", 1'b0, 6'h23, 1'b1, eDecode());
        cycle("lw.addr",   1'b0, 6'h23, 1'b1, eMemAddr());
        cycle("lw.wait0",  1'b0, 6'h23, 1'b0, eMemRead());
        cycle("lw.wait1",  1'b0, 6'h23, 1'b0, eMemRead());
        cycle("lw.read",   1'b0, 6'h23, 1'b1, eMemRead());
        cycle("lw.wb",     1'b0, 6'h23, 1'b1, eMemWb());

        // beq, bne, j back to back
        cycle("beq.fetch",  1'b0, 6'h04, 1'b1, eFetch(1'b1));
        cycle("beq.decode", 1'b0, 6'h04, 1'b1, eDecode());
        cycle("beq.branch", 1'b0, 6'h04, 1'b1, eBranch(1'b1));
        cycle("bne.fetch",  1'b0, 6'h05, 1'b1, eFetch(1'b1));
        cycle("bne.decode", 1'b0, 6'h05, 1'b1, eDecode());
        cycle("bne.branch", 1'b0, 6'h05, 1'b1, eBranch(1'b0));
        runJump("j0");

        // I-type ALU ops: zero-extend for logical, sign-extend for arithmetic
        for (int i = 0; i < 5; i++) begin
            cycle($sformatf("i%0h.fetch", iOps[i]),  1'b0, iOps[i], 1'b1, eFetch(1'b1));
            cycle($sformatf("i%0h.decode", iOps[i]), 1'b0, iOps[i], 1'b1, eDecode());
            cycle($sformatf("i%0h.exec", iOps[i]),   1'b0, iOps[i], 1'b1, eExecI(iExt[i]));
            cycle($sformatf("i%0h.wb", iOps[i]),     1'b0, iOps[i], 1'b1, eWbI());
        end

        // sw with a fetch wait and one write wait
        cycle("sw.fwait",  1'b0, 6'h2B, 1'b0, eFetch(1'b0));
        cycle("sw.fetch",  1'b0, 6'h2B, 1'b1, eFetch(1'b1));
        cycle("sw.decode", 1'b0, 6'h2B, 1'b1, eDecode());
        cycle("sw.addr",   1'b0, 6'h2B, 1'b1, eMemAddr());
        cycle("sw.wait",   1'b0, 6'h2B, 1'b0, eMemWrite(1'b0));
        cycle("sw.write",  1'b0, 6'h2B, 1'b1, eMemWrite(1'b1));

        // Five more jumps bring the total to 16, wrapping the 4-bit counter
        for (int i = 0; i < 5; i++) runJump($sformatf("jw%0d", i));

        // Illegal opcode: absorbing TRAP, counter frozen, reset escapes
        cycle("trap.fetch",  1'b0, 6'h3F, 1'b1, eFetch(1'b1));
        cycle("trap.decode", 1'b0, 6'h3F, 1'b1, eDecode());
        for (int i = 0; i < 12; i++)
            cycle($sformatf("trap.hold%0d", i), 1'b0, 6'h3F, i[0], eTrap());
        cycle("trap.rst",   1'b1, 6'h3F, 1'b1, eTrap());
        cycle("trap.idle",  1'b0, 6'h00, 1'b1, '0);

        // Reset during a stalled store aborts it
        runJump("ja");
        cycle("swa.fetch",  1'b0, 6'h2B, 1'b1, eFetch(1'b1));
        cycle("swa.decode", 1'b0, 6'h2B, 1'b1, eDecode());
        cycle("swa.addr",   1'b0, 6'h2B, 1'b1, eMemAddr());
        cycle("swa.wait",   1'b0, 6'h2B, 1'b0, eMemWrite(1'b0));
        cycle("swa.rst",    1'b1, 6'h2B, 1'b0, eMemWrite(1'b0));
        cycle("swa.idle",   1'b0, 6'h2B, 1'b0, '0);
        cycle("swa.refetch", 1'b0, 6'h2B, 1'b0, eFetch(1'b0));

        check("sb.empty", sbQ.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
